prm_edge_walker: RTL

Edge-sampling sequencer for the PRM roadmap builder. Accepts one roadmap edge as a pair of quantized arm configurations. Walks the edge one bin-step at a time, presenting each intermediate 15-bit configuration code to an attached combinational obstacle checker (any `prm_oblgc_chkNN`). Reports whether the edge is blocked, and at which sample, to the roadmap-graph writer downstream.

---
 rtl/prm_pkg.sv | 20 ++
 rtl/prm_edge_step.sv | 33 +++
 rtl/prm_edge_walker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/prm_pkg.sv
// rtl/prm_pkg.sv - shared types and constants for the PRM edge walker
//
// Holds the default joint geometry (NJ joints of JW bits, CW-bit code),
// the joint-index and config-code typedefs, and the walker FSM state enum.
package prm_pkg;

   localparam int NJ = 5;
   localparam int JW = 3;
   localparam int CW = NJ * JW;

   typedef logic [JW-1:0] joint_t;
   typedef logic [CW-1:0] code_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/prm_edge_step.sv
// rtl/prm_edge_step.sv - one bin-step of a configuration toward its goal
//
// Purely combinational.
// Ports:
//   cur     in  CW  current configuration code
//   goal    in  CW  goal configuration code
//   nxt     out CW  cur with every unequal joint moved one bin toward goal
//   at_goal out 1   cur equals goal
module prm_edge_step #(
   parameter int  NJ = 5,
   parameter int  JW = 3,
   localparam int CW = NJ * JW
) (
   input  logic [CW-1:0] cur,
   input  logic [CW-1:0] goal,
   output logic [CW-1:0] nxt,
   output logic          at_goal
);

   // Joints only move toward goal, so they stay inside 0..2^JW-1 and never wrap.
   always_comb begin
      nxt = cur;
      for (int j = 0; j < NJ; j++) begin
         if (cur[j*JW +: JW] < goal[j*JW +: JW])
            nxt[j*JW +: JW] = cur[j*JW +: JW] + JW'(1);
         else if (cur[j*JW +: JW] > goal[j*JW +: JW])
            nxt[j*JW +: JW] = cur[j*JW +: JW] - JW'(1);
      end
   end

   assign at_goal = (cur == goal);

endmodule

// File: rtl/prm_edge_walker.sv
// rtl/prm_edge_walker.sv - walks one roadmap edge sample by sample against an obstacle checker
//
// Optional feature macro: PRM_EDGE_EARLY_EXIT_EN (stop walking on the first hit).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            edge request handshake
//   in_start, in_goal, in_id     edge endpoints (CW bits each) and tag
//   chk_code, chk_en             live sample presented to the checker
//   chk_hit                      checker response, combinational from chk_code
//   out_valid/out_ready          result handshake
//   out_id, out_blocked,
//   out_hit_idx, out_nsamp       result fields, stable while out_valid is held
module prm_edge_walker #(
   parameter int  NJ   = 5,
   parameter int  JW   = 3,
   parameter int  ID_W = 8,
   localparam int CW   = NJ * JW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CW-1:0]   in_start,
   input  logic [CW-1:0]   in_goal,
   input  logic [ID_W-1:0] in_id,
   output logic [CW-1:0]   chk_code,
   output logic            chk_en,
   input  logic            chk_hit,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ID_W-1:0] out_id,
   output logic            out_blocked,
   output logic [2:0]      out_hit_idx,
   output logic [3:0]      out_nsamp
);

   import prm_pkg::*;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cur;
   logic [CW-1:0]   goal;
   logic [CW-1:0]   cur_step;
   logic            at_goal;
   logic [ID_W-1:0] id;
   logic            blocked;
   logic [2:0]      hit_idx;
   logic [3:0]      cnt;
   logic            last_samp;

   prm_edge_step #(
      .NJ (NJ),
      .JW (JW)
   ) u_step (
      .cur     (cur),
      .goal    (goal),
      .nxt     (cur_step),
      .at_goal (at_goal)
   );

`ifdef PRM_EDGE_EARLY_EXIT_EN
   assign last_samp = at_goal | chk_hit;
`else
   assign last_samp = at_goal;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nxt = ST_WALK;
         ST_WALK: if (last_samp) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      chk_en    = (state == ST_WALK);
      out_valid = (state == ST_DONE);
      chk_code  = chk_en ? cur : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= '0;
         goal    <= '0;
         id      <= '0;
         blocked <= 1'b0;
         hit_idx <= 3'd0;
         cnt     <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  cur     <= in_start;
                  goal    <= in_goal;
                  id      <= in_id;
                  blocked <= 1'b0;
                  hit_idx <= 3'd0;
                  cnt     <= 4'd0;
               end
            end
            ST_WALK: begin
               cnt <= cnt + 4'd1;
               // Only the first hit is recorded; cnt is the index of the current sample.
               if (chk_hit && !blocked) begin
                  blocked <= 1'b1;
                  hit_idx <= cnt[2:0];
               end
               if (!at_goal)
                  cur <= cur_step;
            end
            default: ;
         endcase
      end
   end

   assign out_id      = id;
   assign out_blocked = blocked;
   assign out_hit_idx = hit_idx;
   assign out_nsamp   = cnt;

endmodule
